// File: rtl/rgb_cmd_pkg.sv
// ============================================================================
// Module  : rgb_cmd_pkg
// Purpose : Shared states, ASCII constants and message ROM for rgb_cmd_sequencer.
//           Macro RGB_CMD_ERR_MSG_EN adds the "Error\n" message and its state.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package rgb_cmd_pkg;

    typedef enum logic [2:0] {
        ST_PRINT_READY = 3'd0,
        ST_AWAIT       = 3'd1,
        ST_CHECK       = 3'd2,
`ifdef RGB_CMD_ERR_MSG_EN
        ST_PRINT_ACK   = 3'd3,
        ST_PRINT_ERR   = 3'd4
`else
        ST_PRINT_ACK   = 3'd3
`endif
    } top_state_t;

    typedef enum logic [0:0] {
        TX_SEND = 1'b0,
        TX_WAIT = 1'b1
    } print_state_t;

    localparam logic [7:0] c_lf   = 8'h0A;
    localparam logic [7:0] c_cr   = 8'h0D;
    localparam logic [7:0] c_zero = 8'h30;
    localparam logic [7:0] c_one  = 8'h31;
    localparam logic [7:0] c_nul  = 8'h00;

    localparam int c_rom_len = 23;
    localparam int c_idx_w   = $clog2(c_rom_len);

    typedef logic [c_idx_w-1:0] rom_idx_t;

    localparam rom_idx_t c_ready_ofs = rom_idx_t'(0);
    localparam rom_idx_t c_ack_ofs   = rom_idx_t'(7);
`ifdef RGB_CMD_ERR_MSG_EN
    localparam rom_idx_t c_err_ofs   = rom_idx_t'(16);
`endif

    // Null-terminated messages packed back to back.
    function automatic logic [7:0] msg_rom(input rom_idx_t idx);
        logic [7:0] b;
        case (int'(idx))
            0:  b = 8'h52;  1:  b = 8'h65;  2:  b = 8'h61;  3:  b = 8'h64;
            4:  b = 8'h79;  5:  b = c_lf;
            7:  b = 8'h43;  8:  b = 8'h6F;  9:  b = 8'h6E;  10: b = 8'h74;
            11: b = 8'h72;  12: b = 8'h6F;  13: b = 8'h6C;  14: b = c_lf;
`ifdef RGB_CMD_ERR_MSG_EN
            16: b = 8'h45;  17: b = 8'h72;  18: b = 8'h72;  19: b = 8'h6F;
            20: b = 8'h72;  21: b = c_lf;
`endif
            default: b = c_nul;
        endcase
        return b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rgb_cmd_sequencer_token_buffer.sv
// ============================================================================
// Module  : cmd_token_buffer
// Purpose : Byte shifter with saturating length; decodes a '0'/'1' token.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module cmd_token_buffer
    import rgb_cmd_pkg::*;
#(
    parameter int TOKEN_LEN = 6
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 i_clear,
    input  logic                 i_shift_en,
    input  logic [7:0]           i_shift_byte,
    output logic                 o_valid,
    output logic [TOKEN_LEN-1:0] o_ctrl
);

    localparam int c_len_w = $clog2(TOKEN_LEN + 2);

    logic [7:0]         r_bytes [TOKEN_LEN];
    logic [c_len_w-1:0] r_len;
    logic               w_all_bin;

    always_ff @(posedge clock) begin
        if (reset || i_clear) begin
            for (int i = 0; i < TOKEN_LEN; i++) r_bytes[i] <= c_nul;
            r_len <= '0;
        end else if (i_shift_en) begin
            r_bytes[0] <= i_shift_byte;
            for (int i = 1; i < TOKEN_LEN; i++) r_bytes[i] <= r_bytes[i-1];
            // Stops one past TOKEN_LEN so overlong tokens stay invalid.
            if (r_len != c_len_w'(TOKEN_LEN + 1)) r_len <= r_len + c_len_w'(1);
        end
    end

    // Oldest byte sits at the top index, so it lands in the MSB.
    always_comb begin
        w_all_bin = 1'b1;
        o_ctrl    = '0;
        for (int i = 0; i < TOKEN_LEN; i++) begin
            o_ctrl[i] = r_bytes[i][0];
            if (r_bytes[i] != c_zero && r_bytes[i] != c_one) w_all_bin = 1'b0;
        end
    end

    assign o_valid = (r_len == c_len_w'(TOKEN_LEN)) && w_all_bin;

endmodule

`default_nettype wire

// File: rtl/rgb_cmd_sequencer.sv
// ============================================================================
// Module  : rgb_cmd_sequencer
// Purpose : Prints UART messages and loads the RGB PWM word from "0/1" tokens.
//           Macro RGB_CMD_ERR_MSG_EN enables the "Error\n" reply.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module rgb_cmd_sequencer
    import rgb_cmd_pkg::*;
#(
    parameter int TOKEN_LEN  = 6,
    parameter int TX_TIMEOUT = 0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [7:0]           rx_data,
    input  logic                 rx_done,
    output logic [7:0]           tx_data,
    output logic                 tx_start,
    input  logic                 tx_done,
    output logic [TOKEN_LEN-1:0] ctrl,
    output logic                 ctrl_valid,
    output logic                 rgb_restart,
    output logic                 done
);

    localparam int c_tmr_w = (TX_TIMEOUT > 1) ? $clog2(TX_TIMEOUT) : 1;

    top_state_t          r_top,   w_top_next;
    print_state_t        r_print, w_print_next;
    rom_idx_t            r_idx,   w_idx_next;
    logic [c_tmr_w-1:0]  r_timer, w_timer_next;
    logic [7:0]          r_tx_data, w_tx_data_next;
    logic                r_tx_start, w_tx_start;
    logic [TOKEN_LEN-1:0] r_ctrl;
    logic                r_ctrl_valid, r_done;
    logic                w_load, w_done;
    logic                w_in_print, w_tok_clear, w_tok_shift, w_tok_valid;
    logic [TOKEN_LEN-1:0] w_tok_ctrl;
    logic [7:0]          w_rom;

    assign w_rom = msg_rom(r_idx);
`ifdef RGB_CMD_ERR_MSG_EN
    assign w_in_print = (r_top == ST_PRINT_READY) || (r_top == ST_PRINT_ACK) ||
                        (r_top == ST_PRINT_ERR);
`else
    assign w_in_print = (r_top == ST_PRINT_READY) || (r_top == ST_PRINT_ACK);
`endif

    cmd_token_buffer #(.TOKEN_LEN(TOKEN_LEN)) u_token (
        .clock        (clock),
        .reset        (reset),
        .i_clear      (w_tok_clear),
        .i_shift_en   (w_tok_shift),
        .i_shift_byte (rx_data),
        .o_valid      (w_tok_valid),
        .o_ctrl       (w_tok_ctrl)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_top        <= ST_PRINT_READY;
            r_print      <= TX_SEND;
            r_idx        <= c_ready_ofs;
            r_timer      <= '0;
            r_tx_start   <= 1'b0;
            r_tx_data    <= 8'h00;
            r_ctrl       <= '0;
            r_ctrl_valid <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_top        <= w_top_next;
            r_print      <= w_print_next;
            r_idx        <= w_idx_next;
            r_timer      <= w_timer_next;
            r_tx_start   <= w_tx_start;
            r_tx_data    <= w_tx_data_next;
            r_ctrl_valid <= w_load;
            r_done       <= w_done;
            if (w_load) r_ctrl <= w_tok_ctrl;
        end
    end

    always_comb begin
        w_top_next   = r_top;
        w_print_next = r_print;
        w_idx_next   = r_idx;
        w_timer_next = r_timer;
        if (w_in_print) begin
            if (r_print == TX_SEND) begin
                if (w_rom == c_nul) begin
                    w_top_next = ST_AWAIT;
                end else begin
                    w_print_next = TX_WAIT;
                    w_timer_next = '0;
                end
            end else if (tx_done) begin
                w_idx_next   = r_idx + rom_idx_t'(1);
                w_print_next = TX_SEND;
            end else if (TX_TIMEOUT > 0 && r_timer == c_tmr_w'(TX_TIMEOUT - 1)) begin
                w_top_next   = ST_AWAIT;
                w_print_next = TX_SEND;
            end else begin
                w_timer_next = r_timer + c_tmr_w'(1);
            end
        end else if (r_top == ST_AWAIT) begin
            if (rx_done && rx_data == c_lf) w_top_next = ST_CHECK;
        end else if (r_top == ST_CHECK) begin
            w_print_next = TX_SEND;
            if (w_tok_valid) begin
                w_top_next = ST_PRINT_ACK;
                w_idx_next = c_ack_ofs;
            end else begin
`ifdef RGB_CMD_ERR_MSG_EN
                w_top_next = ST_PRINT_ERR;
                w_idx_next = c_err_ofs;
`else
                w_top_next = ST_AWAIT;
`endif
            end
        end else begin
            w_top_next = ST_PRINT_READY;
            w_idx_next = c_ready_ofs;
        end
    end

    always_comb begin
        w_tx_start     = w_in_print && (r_print == TX_SEND) && (w_rom != c_nul);
        w_tx_data_next = w_tx_start ? w_rom : r_tx_data;
        w_load         = (r_top == ST_CHECK) && w_tok_valid;
        w_done         = (r_top == ST_PRINT_ACK) && (r_print == TX_SEND) && (w_rom == c_nul);
        w_tok_shift    = (r_top == ST_AWAIT) && rx_done && (rx_data != c_lf) && (rx_data != c_cr);
        // Buffer is wiped on the edge that enters AWAIT, ready for a fresh token.
        w_tok_clear    = (w_top_next == ST_AWAIT) && (r_top != ST_AWAIT);
    end

    assign tx_start    = r_tx_start;
    assign tx_data     = r_tx_data;
    assign ctrl        = r_ctrl;
    assign ctrl_valid  = r_ctrl_valid;
    assign rgb_restart = r_ctrl_valid;
    assign done        = r_done;

endmodule

`default_nettype wire

// File: tb/tb_rgb_cmd_sequencer.sv
// Scoreboard bench for rgb_cmd_sequencer: a transmitter model answers tx_start,
// a command-level model predicts ctrl and the printed messages.
`default_nettype none

module tb_rgb_cmd_sequencer;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_done = 1'b0;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_done = 1'b0;
    logic [5:0] ctrl;
    logic       ctrl_valid;
    logic       rgb_restart;
    logic       done;

    rgb_cmd_sequencer dut (
        .clock       (clock),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_done     (rx_done),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .tx_done     (tx_done),
        .ctrl        (ctrl),
        .ctrl_valid  (ctrl_valid),
        .rgb_restart (rgb_restart),
        .done        (done)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clock) cyc <= cyc + 1;

    logic [7:0] exp_tx[$];
    logic [5:0] exp_ctrl[$];
    int         exp_lfcyc[$];
    int         exp_done_cnt = 0;
    int         fixed_delay  = 0;
    logic [7:0] last_tx      = 8'h00;
    logic [5:0] model_ctrl   = 6'd0;
    logic [7:0] cmd_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) exp_tx.push_back(s[i]);
    endtask

    task automatic load_str(input string s);
        cmd_q.delete();
        for (int i = 0; i < s.len(); i++) cmd_q.push_back(s[i]);
    endtask

    // Monitor: pops expectations whenever the DUT presents an event.
    always @(negedge clock) begin
        if (!reset) begin
            if (tx_start) begin
                chk("tx_start_expected", (exp_tx.size() > 0), 1);
                if (exp_tx.size() > 0) chk("tx_byte", tx_data, exp_tx.pop_front());
                last_tx = tx_data;
            end
            if (tx_done) chk("tx_data_hold", tx_data, last_tx);
            if (ctrl_valid || rgb_restart) chk("rgb_restart", rgb_restart, ctrl_valid);
            if (ctrl_valid) begin
                chk("ctrl_valid_expected", (exp_ctrl.size() > 0), 1);
                if (exp_ctrl.size() > 0) begin
                    chk("ctrl_load", ctrl, exp_ctrl.pop_front());
                    chk("ctrl_latency", cyc - exp_lfcyc.pop_front(), 2);
                end
            end
            if (done) begin
                chk("done_expected", (exp_done_cnt > 0), 1);
                if (exp_done_cnt > 0) exp_done_cnt--;
            end
        end
    end

    // Transmitter model: answers each tx_start with a tx_done pulse, abandons on reset.
    initial begin
        int d;
        forever begin
            @(negedge clock);
            if (tx_start && !reset) begin
                d = (fixed_delay > 0) ? fixed_delay : int'($urandom_range(1, 6));
                for (int k = 0; k < d; k++) begin
                    @(posedge clock);
                    if (reset) break;
                end
                if (!reset) begin
                    #1 tx_done = 1'b1;
                    @(posedge clock);
                    #1 tx_done = 1'b0;
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, output int c);
        @(posedge clock);
        #1;
        rx_data = b;
        rx_done = 1'b1;
        c = cyc;
        @(posedge clock);
        #1 rx_done = 1'b0;
    endtask

    // Reference: CRs are dropped, the rest must be exactly six '0'/'1' characters.
    task automatic issue_cmd();
        int n, c;
        bit ok;
        logic [5:0] v;
        n = 0; ok = 1'b1; v = 6'd0;
        foreach (cmd_q[i]) begin
            if (cmd_q[i] != 8'h0A && cmd_q[i] != 8'h0D) begin
                n++;
                if (cmd_q[i] == 8'h30 || cmd_q[i] == 8'h31) v = {v[4:0], cmd_q[i][0]};
                else ok = 1'b0;
            end
        end
        ok = ok && (n == 6);
        if (ok) begin
            model_ctrl = v;
            exp_ctrl.push_back(v);
            push_str("Control\n");
            exp_done_cnt++;
        end else begin
`ifdef RGB_CMD_ERR_MSG_EN
            push_str("Error\n");
`endif
        end
        foreach (cmd_q[i]) begin
            send_byte(cmd_q[i], c);
            if (cmd_q[i] == 8'h0A && ok) exp_lfcyc.push_back(c);
        end
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while ((exp_tx.size() != 0 || exp_ctrl.size() != 0 || exp_done_cnt != 0) && k < budget) begin
            @(posedge clock);
            k++;
        end
        chk("idle_within_budget", (k < budget), 1);
        repeat (fixed_delay + 20) @(posedge clock);
    endtask

    task automatic send_cmd(input string s);
        load_str(s);
        issue_cmd();
        wait_idle(2000);
        chk("ctrl_after_cmd", ctrl, model_ctrl);
    endtask

    initial begin
        int c, len, r;
        bit found;
        fixed_delay = 100;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_tx_start", tx_start, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_ctrl", ctrl, 0);
        chk("rst_ctrl_valid", ctrl_valid, 0);
        chk("rst_rgb_restart", rgb_restart, 0);
        chk("rst_done", done, 0);
        push_str("Ready\n");
        @(posedge clock);
        #1 reset = 1'b0;
        @(posedge clock);
        @(negedge clock);
        chk("first_R_start", tx_start, 1);
        chk("first_R_data", tx_data, 8'h52);
        // Bytes arriving while Ready prints must be lost.
        load_str("111111\n");
        foreach (cmd_q[i]) send_byte(cmd_q[i], c);
        wait_idle(3000);
        chk("ctrl_after_ready", ctrl, 0);
        fixed_delay = 0;

        send_cmd("000001\n");
        send_cmd("011011\n");
        send_cmd("0110111\n");
        send_cmd("01a011\n");
        send_cmd("\r101010\r\n");
        send_cmd("\n");
        send_cmd("11111\n");

        for (int t = 0; t < 12; t++) begin
            cmd_q.delete();
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 8)) : 6;
            for (int j = 0; j < len; j++) begin
                r = int'($urandom_range(0, 19));
                if (r < 9)       cmd_q.push_back(8'h30);
                else if (r < 18) cmd_q.push_back(8'h31);
                else if (r == 18) cmd_q.push_back(8'h0D);
                else             cmd_q.push_back(8'h61);
            end
            cmd_q.push_back(8'h0A);
            issue_cmd();
            wait_idle(2000);
            chk("ctrl_random", ctrl, model_ctrl);
        end

        // Reset in the middle of "Control", right after 'n' goes out.
        load_str("110011\n");
        issue_cmd();
        found = 1'b0;
        for (int k = 0; k < 500 && !found; k++) begin
            @(negedge clock);
            if (tx_start && tx_data == 8'h6E) found = 1'b1;
        end
        chk("saw_n_before_reset", found, 1);
        @(posedge clock);
        #1 reset = 1'b1;
        exp_tx.delete();
        exp_done_cnt = 0;
        model_ctrl   = 6'd0;
        @(posedge clock);
        @(negedge clock);
        chk("midrst_ctrl", ctrl, 0);
        chk("midrst_tx_start", tx_start, 0);
        repeat (2) @(posedge clock);
        push_str("Ready\n");
        #1 reset = 1'b0;
        @(posedge clock);
        @(negedge clock);
        chk("rerelease_R_start", tx_start, 1);
        chk("rerelease_R_data", tx_data, 8'h52);
        wait_idle(2000);
        send_cmd("101101\n");

        chk("exp_tx_empty", exp_tx.size(), 0);
        chk("exp_ctrl_empty", exp_ctrl.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at cycle %0d, expected finish", cyc);
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
